// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if
//   Bundles the serial-side inputs and byte-side outputs of uart_rx_ext.
//   Ports (signals):
//     i_tick       oversampling strobe, one clock wide
//     i_rx         raw serial line, idle high
//     o_rx_data    last received word, right-justified
//     o_rx_valid   one-clock pulse per completed frame
//     o_parity_err parity mismatch in the last frame
//     o_frame_err  a stop bit was sampled low in the last frame
//     o_break      the last frame was a break condition
//   Modports:
//     master  upstream side: drives tick/line, observes the results
//     slave   the receiver itself
interface uart_rx_ext_if #(
   parameter int NB_DATA = 8
);
   logic               i_tick;
   logic               i_rx;
   logic [NB_DATA-1:0] o_rx_data;
   logic               o_rx_valid;
   logic               o_parity_err;
   logic               o_frame_err;
   logic               o_break;

   modport master (
      output i_tick,
      output i_rx,
      input  o_rx_data,
      input  o_rx_valid,
      input  o_parity_err,
      input  o_frame_err,
      input  o_break
   );

   modport slave (
      input  i_tick,
      input  i_rx,
      output o_rx_data,
      output o_rx_valid,
      output o_parity_err,
      output o_frame_err,
      output o_break
   );
endinterface

// File: rtl/uart_rx_ext.sv
// uart_rx_ext
//   Parametrised oversampling UART receiver: NB_DATA data bits (LSB first),
//   optional even/odd parity, NB_STOP stop bits, OVERSAMPLE ticks per bit.
//   The line is synchronised by two flops, each bit is decided by a 3-sample
//   majority vote at the end of its bit period, false starts are rejected at
//   mid-start, and parity/framing/break errors are reported per frame.
//   Ports:
//     i_clk      system clock, rising edge
//     i_reset_n  asynchronous active-low reset
//     bus        uart_rx_ext_if.slave (i_tick, i_rx in; data/valid/flags out)
module uart_rx_ext #(
   parameter int NB_DATA    = 8,
   parameter int NB_STOP    = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int OVERSAMPLE = 16
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   uart_rx_ext_if.slave bus
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(NB_DATA);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE - 3);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_DATA - 1);
   localparam logic             STOP_LAST = 1'(NB_STOP - 1);
   localparam logic             PAR_EN    = 1'(PARITY_EN);
   localparam logic             PAR_ODD   = 1'(PARITY_ODD);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Majority of three line samples.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity check result: 1 means mismatch for the selected parity sense.
   function automatic logic parity_bad(input logic [NB_DATA-1:0] data,
                                       input logic par_bit,
                                       input logic odd);
      return (^data) ^ par_bit ^ odd;
   endfunction

   logic               rx_meta_r;
   logic               rx_sync_r;
   logic               rx_s;
   logic [2:0]         state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [BIT_W-1:0]   bit_cnt_r;
   logic               stop_cnt_r;
   logic [NB_DATA-1:0] shift_r;
   logic [1:0]         samp_r;
   logic               par_bit_r;
   logic               par_err_r;
   logic               stop_err_r;
   logic [NB_DATA-1:0] rx_data_r;
   logic               rx_valid_r;
   logic               parity_err_r;
   logic               frame_err_r;
   logic               break_r;

   logic               vote_s;
   logic [NB_DATA-1:0] shift_next_s;
   logic               frame_err_next_s;
   logic               break_next_s;

   assign rx_s = rx_sync_r;

   // Two-flop synchroniser for the asynchronous line; idles high out of reset.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= bus.i_rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Bit decision and the values a frame completion would commit.
   always_comb begin
      vote_s           = maj3(samp_r[0], samp_r[1], rx_s);
      shift_next_s     = {vote_s, shift_r[NB_DATA-1:1]};
      frame_err_next_s = stop_err_r | ~vote_s;
      // Break needs an all-zero word, a zero parity bit (if any) and a low stop.
      if ((shift_r == {NB_DATA{1'b0}}) && (!PAR_EN || !par_bit_r)) begin
         break_next_s = frame_err_next_s;
      end else begin
         break_next_s = 1'b0;
      end
   end

   // Receive FSM, tick/bit/stop counters, shift register and output registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         bit_cnt_r    <= {BIT_W{1'b0}};
         stop_cnt_r   <= 1'b0;
         shift_r      <= {NB_DATA{1'b0}};
         samp_r       <= 2'b00;
         par_bit_r    <= 1'b0;
         par_err_r    <= 1'b0;
         stop_err_r   <= 1'b0;
         rx_data_r    <= {NB_DATA{1'b0}};
         rx_valid_r   <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         break_r      <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Edge detection runs every clock, not only on ticks.
               if (!rx_s) begin
                  state_r <= ST_START;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            ST_START: begin
               if (bus.i_tick) begin
                  if (cnt_r == CNT_HALF) begin
                     cnt_r <= {CNT_W{1'b0}};
                     if (rx_s) begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_r <= ST_IDLE;
                     end else begin
                        state_r    <= ST_DATA;
                        bit_cnt_r  <= {BIT_W{1'b0}};
                        stop_cnt_r <= 1'b0;
                        par_bit_r  <= 1'b0;
                        par_err_r  <= 1'b0;
                        stop_err_r <= 1'b0;
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
               if (bus.i_tick) begin
                  if (cnt_r == CNT_S0) begin
                     samp_r[0] <= rx_s;
                  end
                  if (cnt_r == CNT_S1) begin
                     samp_r[1] <= rx_s;
                  end
                  if (cnt_r == CNT_LAST) begin
                     cnt_r <= {CNT_W{1'b0}};
                     case (state_r)
                        ST_DATA: begin
                           // First bit on the line ends up in bit 0.
                           shift_r <= shift_next_s;
                           if (bit_cnt_r == BIT_LAST) begin
                              bit_cnt_r <= {BIT_W{1'b0}};
                              state_r   <= PAR_EN ? ST_PARITY : ST_STOP;
                           end else begin
                              bit_cnt_r <= bit_cnt_r + BIT_ONE;
                           end
                        end
                        ST_PARITY: begin
                           par_bit_r <= vote_s;
                           par_err_r <= parity_bad(shift_r, vote_s, PAR_ODD);
                           state_r   <= ST_STOP;
                        end
                        ST_STOP: begin
                           if (stop_cnt_r == STOP_LAST) begin
                              // Complete at mid-stop so a back-to-back start
                              // edge is caught straight away.
                              rx_data_r    <= shift_r;
                              parity_err_r <= par_err_r;
                              frame_err_r  <= frame_err_next_s;
                              break_r      <= break_next_s;
                              rx_valid_r   <= 1'b1;
                              stop_cnt_r   <= 1'b0;
                              stop_err_r   <= 1'b0;
                              state_r      <= ST_IDLE;
                           end else begin
                              stop_err_r <= frame_err_next_s;
                              stop_cnt_r <= stop_cnt_r + 1'b1;
                           end
                        end
                        default: begin
                           state_r <= ST_IDLE;
                        end
                     endcase
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign bus.o_rx_data    = rx_data_r;
   assign bus.o_rx_valid   = rx_valid_r;
   assign bus.o_parity_err = parity_err_r;
   assign bus.o_frame_err  = frame_err_r;
   assign bus.o_break      = break_r;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext
//   Directed bench for uart_rx_ext with three instances sharing clock, reset
//   and tick: A = 8N1, B = 8 data + odd parity + 1 stop, C = 7 data + 2 stop,
//   all at OVERSAMPLE=16. One tick every four clocks.
module tb_uart_rx_ext;

   logic clk;
   logic rst_n;
   logic tick;
   logic rx_a, rx_b, rx_c;

   int n_cmp = 0;
   int n_err = 0;
   int tick_cnt = 0;
   int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
   int last_tick_a = 0;
   int t_start;

   uart_rx_ext_if #(.NB_DATA(8)) if_a ();
   uart_rx_ext_if #(.NB_DATA(8)) if_b ();
   uart_rx_ext_if #(.NB_DATA(7)) if_c ();

   assign if_a.i_tick = tick;
   assign if_b.i_tick = tick;
   assign if_c.i_tick = tick;
   assign if_a.i_rx   = rx_a;
   assign if_b.i_rx   = rx_b;
   assign if_c.i_rx   = rx_c;

   uart_rx_ext u_a (.i_clk(clk), .i_reset_n(rst_n), .bus(if_a));
   uart_rx_ext #(.NB_DATA(8), .NB_STOP(1), .PARITY_EN(1), .PARITY_ODD(1), .OVERSAMPLE(16))
      u_b (.i_clk(clk), .i_reset_n(rst_n), .bus(if_b));
   uart_rx_ext #(.NB_DATA(7), .NB_STOP(2), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16))
      u_c (.i_clk(clk), .i_reset_n(rst_n), .bus(if_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count clocks with valid high; a pulse longer than one clock shows up as extra.
   always @(posedge clk) begin
      if (if_a.o_rx_valid) begin
         vcnt_a      <= vcnt_a + 1;
         last_tick_a <= tick_cnt;
      end
      if (if_b.o_rx_valid) vcnt_b <= vcnt_b + 1;
      if (if_c.o_rx_valid) vcnt_c <= vcnt_c + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      tick_cnt++;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic set_line(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic idle(input int sel, input int n);
      set_line(sel, 1'b1);
      repeat (n) do_tick();
   endtask

   // Line bits LSB first: start, data, optional parity, stop bits (high).
   function automatic logic [15:0] frame_bits(input logic [8:0] data, input int nd,
                                               input int par, input logic pbit);
      logic [15:0] f;
      f    = 16'hFFFF;
      f[0] = 1'b0;
      for (int i = 0; i < nd; i++) f[1+i] = data[i];
      if (par != 0) f[1+nd] = pbit;
      return f;
   endfunction

   task automatic send_bits(input int sel, input logic [15:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         set_line(sel, f[i]);
         repeat (16) do_tick();
      end
   endtask

   // Start + 8 data bits on A with a one-tick inversion that the receiver
   // samples at cnt=14 of each data bit; then a normal stop bit.
   task automatic send_glitchy_a(input logic [7:0] d);
      rx_a = 1'b0;
      repeat (16) do_tick();
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 16; j++) begin
            rx_a = (j == 6) ? ~d[b] : d[b];
            do_tick();
         end
      end
      idle(0, 16);
   endtask

   task automatic check_a(input string tag, input logic [7:0] d, input logic pe,
                          input logic fe, input logic bk, input int nv);
      check({tag, "_valid_cnt"}, 32'(vcnt_a), 32'(nv));
      check({tag, "_data"}, 32'(if_a.o_rx_data), 32'(d));
      check({tag, "_perr"}, 32'(if_a.o_parity_err), 32'(pe));
      check({tag, "_ferr"}, 32'(if_a.o_frame_err), 32'(fe));
      check({tag, "_brk"}, 32'(if_a.o_break), 32'(bk));
   endtask

   initial begin
      rst_n = 1'b0;
      tick  = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      rx_c  = 1'b1;
      repeat (3) @(negedge clk);
      check_a("reset_a", 8'h00, 1'b0, 1'b0, 1'b0, 0);
      check("reset_a_valid", 32'(if_a.o_rx_valid), 32'd0);
      check("reset_c_data", 32'(if_c.o_rx_data), 32'd0);
      rst_n = 1'b1;
      idle(0, 4);

      // 8N1 0xA5. The line falls just before tick t_start+1, which the
      // synchroniser hides, so IDLE is left before tick t_start+2 and the
      // 152-tick frame ends on tick t_start+153.
      t_start = tick_cnt;
      send_bits(0, frame_bits(9'h0A5, 8, 0, 1'b0), 10);
      idle(0, 8);
      check_a("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1);
      check("a5_latency_ticks", 32'(last_tick_a - t_start), 32'd153);

      // Odd parity, 0x03 has two ones: parity bit 0 is wrong, 1 is right.
      send_bits(1, frame_bits(9'h003, 8, 1, 1'b0), 11);
      idle(1, 8);
      check("par0_valid_cnt", 32'(vcnt_b), 32'd1);
      check("par0_data", 32'(if_b.o_rx_data), 32'h03);
      check("par0_perr", 32'(if_b.o_parity_err), 32'd1);
      check("par0_ferr", 32'(if_b.o_frame_err), 32'd0);
      send_bits(1, frame_bits(9'h003, 8, 1, 1'b1), 11);
      idle(1, 8);
      check("par1_valid_cnt", 32'(vcnt_b), 32'd2);
      check("par1_data", 32'(if_b.o_rx_data), 32'h03);
      check("par1_perr", 32'(if_b.o_parity_err), 32'd0);
      check("par1_brk", 32'(if_b.o_break), 32'd0);

      // Four-tick low glitch: rejected at mid-start, previous results held.
      rx_a = 1'b0;
      repeat (4) do_tick();
      idle(0, 40);
      check_a("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 1);
      send_bits(0, frame_bits(9'h03C, 8, 0, 1'b0), 10);
      idle(0, 8);
      check_a("after_glitch", 8'h3C, 1'b0, 1'b0, 1'b0, 2);

      // Stop bit low long enough to cover the vote, then back high before the
      // receiver's mid-start check so no second frame is started.
      send_bits(0, frame_bits(9'h07E, 8, 0, 1'b0), 9);
      rx_a = 1'b0;
      repeat (12) do_tick();
      idle(0, 30);
      check_a("stop_low", 8'h7E, 1'b0, 1'b1, 1'b0, 3);

      // Break: line low through start, data and the stop vote.
      rx_a = 1'b0;
      repeat (156) do_tick();
      idle(0, 30);
      check_a("break", 8'h00, 1'b0, 1'b1, 1'b1, 4);

      // Majority vote removes a one-sample glitch in every data bit.
      send_glitchy_a(8'h55);
      idle(0, 8);
      check_a("vote", 8'h55, 1'b0, 1'b0, 1'b0, 5);

      // 7-bit, 2 stop: back-to-back frames, then reset during a third.
      send_bits(2, frame_bits(9'h041, 7, 0, 1'b0), 10);
      check("c41_valid_cnt", 32'(vcnt_c), 32'd1);
      check("c41_data", 32'(if_c.o_rx_data), 32'h41);
      check("c41_ferr", 32'(if_c.o_frame_err), 32'd0);
      send_bits(2, frame_bits(9'h05A, 7, 0, 1'b0), 10);
      check("c5a_valid_cnt", 32'(vcnt_c), 32'd2);
      check("c5a_data", 32'(if_c.o_rx_data), 32'h5A);
      check("c5a_perr", 32'(if_c.o_parity_err), 32'd0);
      send_bits(2, frame_bits(9'h07F, 7, 0, 1'b0), 4);
      repeat (8) do_tick();
      @(negedge clk);
      rst_n = 1'b0;
      rx_c  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_c_data", 32'(if_c.o_rx_data), 32'd0);
      check("rst_c_valid", 32'(if_c.o_rx_valid), 32'd0);
      check("rst_c_ferr", 32'(if_c.o_frame_err), 32'd0);
      check("rst_c_brk", 32'(if_c.o_break), 32'd0);
      check_a("rst_a", 8'h00, 1'b0, 1'b0, 1'b0, 5);
      check("rst_b_perr", 32'(if_b.o_parity_err), 32'd0);
      rst_n = 1'b1;
      idle(2, 200);
      check("rst_c_no_pulse", 32'(vcnt_c), 32'd2);
      check("rst_c_data_held", 32'(if_c.o_rx_data), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
